// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - start/stop/reload controller for an external down-counter
// Prescaled tick generator, one-shot or periodic expiry, sticky interrupt flag.
module counter_ctrl #(
    parameter int W = 16
) (
    input  logic         i_sysclk,
    input  logic         i_sysrst,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic         i_hold,
    input  logic         i_mode,
    input  logic [W-1:0] i_period,
    input  logic [7:0]   i_presc,
    input  logic         i_irq_ack,
    input  logic [W-1:0] i_cnt,
    output logic         o_ld,
    output logic [W-1:0] o_ld_data,
    output logic         o_clr,
    output logic         o_cnt_en,
    output logic         o_dir,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   pcnt_q, pcnt_d;
    logic [W-1:0] period_q, period_d;
    logic [7:0]   presc_q, presc_d;
    logic         mode_q, mode_d;
    logic         irq_q, irq_d;

    logic ld, clr, cnt_en, done;

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            state_q  <= ST_IDLE;
            pcnt_q   <= '0;
            period_q <= '0;
            presc_q  <= '0;
            mode_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            presc_q  <= presc_d;
            mode_q   <= mode_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        period_d = period_q;
        presc_d  = presc_q;
        mode_d   = mode_q;
        ld       = 1'b0;
        clr      = 1'b0;
        cnt_en   = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    period_d = i_period;
                    presc_d  = i_presc;
                    mode_d   = i_mode;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (i_stop) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ld      = 1'b1;
                    pcnt_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stop outranks hold and expiry; hold freezes the prescaler in place.
                if (i_stop) begin
                    clr     = 1'b1;
                    pcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (!i_hold) begin
                    if (pcnt_q == presc_q) begin
                        pcnt_d = '0;
                        if (i_cnt != '0) begin
                            cnt_en = 1'b1;
                        end else begin
                            done = 1'b1;
                            if (mode_q) begin
                                ld = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        pcnt_d = pcnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Set outranks acknowledge when both land in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if (done) begin
            irq_d = 1'b1;
        end else if (i_irq_ack) begin
            irq_d = 1'b0;
        end
    end

    // Outputs are forced low while reset is asserted, before the state has settled.
    assign o_ld      = ld & ~i_sysrst;
    assign o_ld_data = o_ld ? period_q : '0;
    assign o_clr     = clr & ~i_sysrst;
    assign o_cnt_en  = cnt_en & ~i_sysrst;
    assign o_done    = done & ~i_sysrst;
    assign o_dir     = 1'b0;
    assign o_busy    = (state_q != ST_IDLE) & ~i_sysrst;
    assign o_irq     = irq_q & ~i_sysrst;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - randomized scoreboard bench for counter_ctrl
module tb_counter_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, stop = 1'b0, hold = 1'b0, mode = 1'b0, ack = 1'b0;
    logic [W-1:0] period = '0;
    logic [7:0]   presc = '0;
    logic [W-1:0] cnt;
    logic         o_ld, o_clr, o_cnt_en, o_dir, o_busy, o_done, o_irq;
    logic [W-1:0] o_ld_data;

    always #5 clk = ~clk;

    counter_ctrl #(.W(W)) dut (
        .i_sysclk (clk),
        .i_sysrst (rst),
        .i_start  (start),
        .i_stop   (stop),
        .i_hold   (hold),
        .i_mode   (mode),
        .i_period (period),
        .i_presc  (presc),
        .i_irq_ack(ack),
        .i_cnt    (cnt),
        .o_ld     (o_ld),
        .o_ld_data(o_ld_data),
        .o_clr    (o_clr),
        .o_cnt_en (o_cnt_en),
        .o_dir    (o_dir),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_irq    (o_irq)
    );

    // The controlled down-counter
    always @(posedge clk) begin
        if (rst)           cnt <= '0;
        else if (o_clr)    cnt <= '0;
        else if (o_ld)     cnt <= o_ld_data;
        else if (o_cnt_en) cnt <= cnt - 1'b1;
    end

    typedef struct {
        int           cyc;
        logic         ld;
        logic         clr;
        logic         en;
        logic         done;
        logic [W-1:0] data;
    } ev_t;

    ev_t  sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;
    bit   exp_busy = 1'b0;
    bit   exp_irq = 1'b0;

    // Reference model: phase 0 idle, 1 load, 2 run; m_k counts unheld run cycles
    int           m_st = 0;
    int           m_k = 0;
    logic [W-1:0] m_p = '0;
    int           m_r = 0;
    bit           m_mode = 1'b0;
    bit           m_irq = 1'b0;

    task automatic step(input bit r, input bit st, input bit sp, input bit hd, input bit ak,
                        input bit md, input logic [W-1:0] per, input logic [7:0] ps);
        ev_t e;
        int  nst;
        bit  irq_n;
        @(posedge clk);
        #1;
        rst = r; start = st; stop = sp; hold = hd; ack = ak; mode = md; period = per; presc = ps;
        cyc++;
        e = '{cyc: cyc, ld: 1'b0, clr: 1'b0, en: 1'b0, done: 1'b0, data: '0};
        nst = m_st;
        irq_n = m_irq;
        if (r) begin
            exp_busy = 1'b0;
            exp_irq  = 1'b0;
            nst      = 0;
            irq_n    = 1'b0;
            m_k      = 0;
        end else begin
            exp_busy = (m_st != 0);
            exp_irq  = m_irq;
            case (m_st)
                0: if (st && !sp) begin
                    m_p = per; m_r = int'(ps); m_mode = md; nst = 1;
                end
                1: if (sp) begin
                    e.clr = 1'b1; nst = 0;
                end else begin
                    e.ld = 1'b1; e.data = m_p; nst = 2; m_k = 0;
                end
                default: if (sp) begin
                    e.clr = 1'b1; nst = 0;
                end else if (!hd) begin
                    m_k++;
                    if (m_k == (int'(m_p) + 1) * (m_r + 1)) begin
                        e.done = 1'b1;
                        m_k = 0;
                        if (m_mode) begin
                            e.ld = 1'b1; e.data = m_p;
                        end else begin
                            nst = 0;
                        end
                    end else if (m_k % (m_r + 1) == 0) begin
                        e.en = 1'b1;
                    end
                end
            endcase
            irq_n = e.done ? 1'b1 : (ak ? 1'b0 : m_irq);
        end
        if (e.ld || e.clr || e.en || e.done) sb.push_back(e);
        m_st  = nst;
        m_irq = irq_n;
        mon_on = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_on) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_vec++; n_bad++;
                $display("FAIL missing_strobe: cycle %0d got nothing, required ld=%0b clr=%0b en=%0b done=%0b",
                         e.cyc, e.ld, e.clr, e.en, e.done);
            end
            if (o_ld || o_clr || o_cnt_en || o_done) begin
                n_vec++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_bad++;
                    $display("FAIL unexpected_strobe: cycle %0d got ld=%0b clr=%0b en=%0b done=%0b, required none",
                             cyc, o_ld, o_clr, o_cnt_en, o_done);
                end else begin
                    e = sb.pop_front();
                    if ({o_ld, o_clr, o_cnt_en, o_done} != {e.ld, e.clr, e.en, e.done} || o_ld_data != e.data) begin
                        n_bad++;
                        $display("FAIL strobe: cycle %0d got ld=%0b clr=%0b en=%0b done=%0b data=%0d, required ld=%0b clr=%0b en=%0b done=%0b data=%0d",
                                 cyc, o_ld, o_clr, o_cnt_en, o_done, o_ld_data, e.ld, e.clr, e.en, e.done, e.data);
                    end
                end
            end
            n_vec++;
            if (o_busy !== exp_busy) begin
                n_bad++;
                $display("FAIL busy: cycle %0d got %0b, required %0b", cyc, o_busy, exp_busy);
            end
            n_vec++;
            if (o_irq !== exp_irq) begin
                n_bad++;
                $display("FAIL irq: cycle %0d got %0b, required %0b", cyc, o_irq, exp_irq);
            end
            n_vec++;
            if ((o_ld && o_clr) || (o_ld && o_cnt_en) || o_dir !== 1'b0 || (!o_ld && o_ld_data != '0)) begin
                n_bad++;
                $display("FAIL exclusivity: cycle %0d got ld=%0b clr=%0b en=%0b dir=%0b data=%0d, required exclusive strobes, dir 0, data 0 without ld",
                         cyc, o_ld, o_clr, o_cnt_en, o_dir, o_ld_data);
            end
            n_vec++;
            if (cnt > 16'd255) begin
                n_bad++;
                $display("FAIL counter_wrap: cycle %0d got %0d, required at most 255", cyc, cnt);
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, '0, '0);
        step(1, 1, 0, 0, 0, 1, 16'd9, 8'd3);
        step(1, 0, 0, 0, 0, 0, '0, '0);
        // One-shot period 3, presc 0
        step(0, 1, 0, 0, 0, 0, 16'd3, 8'd0);
        idle(8);
        // Periodic period 2, presc 1, then stop mid-run
        step(0, 1, 0, 0, 0, 1, 16'd2, 8'd1);
        idle(20);
        step(0, 0, 1, 0, 0, 0, '0, '0);
        idle(2);
        // Acknowledge coincident with expiry, then one cycle later
        step(0, 1, 0, 0, 0, 0, 16'd0, 8'd0);
        idle(1);
        step(0, 0, 0, 0, 1, 0, '0, '0);
        step(0, 0, 0, 0, 1, 0, '0, '0);
        idle(2);
        // Hold four cycles mid-run with presc 2
        step(0, 1, 0, 0, 0, 0, 16'd3, 8'd2);
        idle(4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, '0, '0);
        idle(12);
        // Reset mid-run, then start with stop together
        step(0, 1, 0, 0, 0, 1, 16'd4, 8'd1);
        idle(5);
        step(1, 0, 0, 0, 0, 0, '0, '0);
        step(0, 1, 1, 0, 0, 0, 16'd2, 8'd0);
        idle(3);
        step(0, 1, 0, 0, 0, 1, 16'd5, 8'd0);
        idle(4);
        step(0, 0, 1, 0, 0, 0, '0, '0);
        idle(2);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 W'($urandom_range(0, 6)), 8'($urandom_range(0, 3)));
        end
        step(0, 0, 1, 0, 0, 0, '0, '0);
        idle(3);
        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The module SHALL have one parameter, W, default 16, the counter data width in bits.
REQ-002 The module SHALL have these ports (name  direction  width  meaning):
- i_sysclk  in  1  system clock; single clock domain, all logic on rising edge
- i_sysrst  in  1  system reset; synchronous, active-high
- i_start  in  1  start request; one-cycle pulse or level
- i_stop  in  1  abort request
- i_hold  in  1  pause counting while high
- i_mode  in  1  0 = one-shot, 1 = periodic
- i_period  in  W  reload value
- i_presc  in  8  prescaler; one tick every i_presc+1 cycles
- i_irq_ack  in  1  clears o_irq
- i_cnt  in  W  current value of the controlled counter
- o_ld  out  1  counter load strobe
- o_ld_data  out  W  counter load value
- o_clr  out  1  counter clear strobe
- o_cnt_en  out  1  counter count enable
- o_dir  out  1  counter direction; tied 0 (down)
- o_busy  out  1  high in LOAD and RUN
- o_done  out  1  one-cycle expiry pulse
- o_irq  out  1  sticky expiry flag

Function
REQ-003 The module SHALL implement the FSM states IDLE, LOAD and RUN.
REQ-004 In IDLE, i_start=1 with i_stop=0 SHALL latch i_period, i_presc and i_mode into internal registers and move the FSM to LOAD on the next edge.
REQ-005 In LOAD, the module SHALL drive o_ld=1 and o_ld_data=latched period for exactly one cycle, then move to RUN, with the prescaler count set to 0.
REQ-006 In RUN with i_hold=0, the prescaler count SHALL increment each cycle, and a tick SHALL occur in the cycle where the count equals the latched presc; the count then returns to 0.
REQ-007 On a tick in RUN with i_cnt!=0, the module SHALL drive o_cnt_en=1 for that cycle only.
REQ-008 On a tick in RUN with i_cnt==0 (expiry), the module SHALL hold o_cnt_en=0, so the counter never wraps, and SHALL pulse o_done=1 for that cycle.
REQ-009 On expiry in periodic mode, the module SHALL drive o_ld=1 and o_ld_data=latched period in the same cycle and stay in RUN.
REQ-010 On expiry in one-shot mode, the module SHALL return to IDLE on the next edge, leaving the counter at 0.
REQ-011 One expiry period SHALL be exactly (period+1)*(presc+1) cycles; a period of 0 SHALL expire on the first tick.
REQ-012 With i_hold=1 in RUN, the prescaler SHALL freeze, o_cnt_en SHALL be 0 and no expiry SHALL occur; counting SHALL resume from the frozen prescaler value when i_hold falls.
REQ-013 i_hold SHALL have no effect in IDLE or LOAD.
REQ-014 i_stop=1 in LOAD or RUN SHALL drive o_clr=1 and o_ld=o_cnt_en=o_done=0 in that cycle, with the FSM in IDLE on the next edge.
REQ-015 i_stop SHALL have priority over start, hold and expiry.
REQ-016 i_stop in IDLE SHALL be ignored; o_clr=0.
REQ-017 i_start in LOAD or RUN SHALL be ignored; a restart requires i_stop first.
REQ-018 o_ld and o_clr SHALL never be high in the same cycle, and o_ld and o_cnt_en SHALL never be high in the same cycle.
REQ-019 o_irq SHALL be set on the edge after o_done=1 and cleared on the edge after i_irq_ack=1; when both occur in the same cycle, the set SHALL win.
REQ-020 o_busy SHALL be high exactly when the FSM is in LOAD or RUN.
REQ-021 The strobes o_ld, o_clr, o_cnt_en and o_done SHALL be decoded combinationally from the state, registers and inputs, with no extra pipeline stage.
REQ-022 o_ld_data SHALL equal the latched period whenever o_ld=1, and SHALL be 0 otherwise.

Reset
REQ-023 i_sysrst=1 SHALL force, on the next edge, state=IDLE, prescaler count=0, latched period/presc/mode=0 and o_irq=0.
REQ-024 Reset SHALL have priority over every other input, including when asserted mid-RUN.
REQ-025 While in reset and in the cycle after reset, all outputs SHALL be 0.

Verification
REQ-026 One-shot, period=3, presc=0, i_start in cycle 0 -> o_ld=1 with data 3 in cycle 1; o_cnt_en=1 in cycles 2,3,4 (i_cnt 3,2,1); o_done=1 in cycle 5; o_irq=1 from cycle 6; o_busy=0 from cycle 6.
REQ-027 Periodic, period=2, presc=1 -> o_done pulses exactly every 6 cycles, each coincident with o_ld=1 and data 2; i_cnt sequence 2,2,1,1,0,0 repeats; no wrap to 0xFFFF.
REQ-028 i_stop in RUN with i_cnt=5 -> o_clr=1 in that cycle, no o_done; IDLE, o_busy=0 and i_cnt=0 afterwards; a following i_start is accepted.
REQ-029 i_hold high for 4 cycles mid-RUN, presc=2 -> no o_cnt_en during the hold; expiry is delayed by exactly 4 cycles versus the unheld run.
REQ-030 i_irq_ack in the same cycle as o_done with o_irq already 1 -> o_irq stays 1; i_irq_ack one cycle later -> o_irq=0.
REQ-031 i_sysrst in RUN, then i_start together with i_stop -> all outputs 0 after reset; FSM remains IDLE (stop wins); o_irq=0.
